// File: rtl/ec_scalar_mul_ctrl_if.sv
// Host and point-datapath signals of the EC scalar-multiply controller.
// The controller takes the slave view; the host / datapath side takes the master view.
interface ec_scalar_mul_ctrl_if #(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned K_WIDTH = 6
) ();
  // Host side
  logic               in_valid;
  logic [K_WIDTH-1:0] in_k;
  logic [WIDTH-1:0]   in_Px;
  logic [WIDTH-1:0]   in_Py;
  logic [WIDTH-1:0]   in_prime;
  logic [WIDTH-1:0]   in_a;
  logic               busy;
  logic               out_valid;
  logic [WIDTH-1:0]   out_Rx;
  logic [WIDTH-1:0]   out_Ry;
  logic               out_inf;
  logic               out_err;

  // Datapath side
  logic               ec_in_valid;
  logic [WIDTH-1:0]   ec_Px;
  logic [WIDTH-1:0]   ec_Py;
  logic [WIDTH-1:0]   ec_Qx;
  logic [WIDTH-1:0]   ec_Qy;
  logic [WIDTH-1:0]   ec_prime;
  logic [WIDTH-1:0]   ec_a;
  logic               ec_out_valid;
  logic [WIDTH-1:0]   ec_Rx;
  logic [WIDTH-1:0]   ec_Ry;

  modport master (
    output in_valid, in_k, in_Px, in_Py, in_prime, in_a,
    input  busy, out_valid, out_Rx, out_Ry, out_inf, out_err,
    input  ec_in_valid, ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a,
    output ec_out_valid, ec_Rx, ec_Ry
  );

  modport slave (
    input  in_valid, in_k, in_Px, in_Py, in_prime, in_a,
    output busy, out_valid, out_Rx, out_Ry, out_inf, out_err,
    output ec_in_valid, ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a,
    input  ec_out_valid, ec_Rx, ec_Ry
  );
endinterface

// File: rtl/ec_scalar_mul_ctrl.sv
// Left-to-right double-and-add sequencer for an external EC point add/double datapath.
// Tracks the point at infinity locally. Define ECSM_WATCHDOG_EN to abort stalled datapath ops.
module ec_scalar_mul_ctrl #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned K_WIDTH  = 6,
  parameter int unsigned WD_LIMIT = 31
) (
  input logic                 clk,
  input logic                 rst_n,
  ec_scalar_mul_ctrl_if.slave bus
);

  localparam int unsigned IdxW = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StDblWait,
    StAdd,
    StAddWait,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Latched job operands
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0]   px_q, px_d;
  logic [WIDTH-1:0]   py_q, py_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]   a_q, a_d;

  // Accumulator R and its infinity flag
  logic [WIDTH-1:0]   rx_q, rx_d;
  logic [WIDTH-1:0]   ry_q, ry_d;
  logic               inf_q, inf_d;
  logic [IdxW-1:0]    idx_q, idx_d;

  // Datapath issue registers
  logic               ec_valid_q, ec_valid_d;
  logic [WIDTH-1:0]   ec_px_q, ec_px_d;
  logic [WIDTH-1:0]   ec_py_q, ec_py_d;
  logic [WIDTH-1:0]   ec_qx_q, ec_qx_d;
  logic [WIDTH-1:0]   ec_qy_q, ec_qy_d;

  // Host-facing output registers
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_rx_q, out_rx_d;
  logic [WIDTH-1:0]   out_ry_q, out_ry_d;
  logic               out_inf_q, out_inf_d;
  logic               out_err_q, out_err_d;

  logic               bit_done;
  logic               wd_abort;

`ifdef ECSM_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WD_LIMIT + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           waiting;

  // Counter is zero outside the wait states, so every new issue starts a fresh count.
  always_comb begin
    waiting  = (state_q == StDblWait || state_q == StAddWait) && !bus.ec_out_valid;
    wd_d     = '0;
    wd_abort = 1'b0;
    if (waiting) begin
      if (wd_q == WdW'(WD_LIMIT - 1)) begin
        wd_abort = 1'b1;
      end else begin
        wd_d = wd_q + WdW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_wd_limit;
  assign unused_wd_limit = ^WD_LIMIT;
  assign wd_abort        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    px_d        = px_q;
    py_d        = py_q;
    p_d         = p_q;
    a_d         = a_q;
    rx_d        = rx_q;
    ry_d        = ry_q;
    inf_d       = inf_q;
    idx_d       = idx_q;
    ec_valid_d  = 1'b0;
    ec_px_d     = ec_px_q;
    ec_py_d     = ec_py_q;
    ec_qx_d     = ec_qx_q;
    ec_qy_d     = ec_qy_q;
    out_valid_d = 1'b0;
    out_rx_d    = '0;
    out_ry_d    = '0;
    out_inf_d   = 1'b0;
    out_err_d   = 1'b0;
    bit_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          k_d     = bus.in_k;
          px_d    = bus.in_Px;
          py_d    = bus.in_Py;
          p_d     = bus.in_prime;
          a_d     = bus.in_a;
          rx_d    = '0;
          ry_d    = '0;
          inf_d   = 1'b1;
          idx_d   = IdxW'(K_WIDTH - 1);
          state_d = StScan;
        end
      end

      StScan: begin
        if (inf_q) begin
          // Doubling O is O; the add step then reduces to R = P or nothing.
          if (k_q[idx_q]) begin
            rx_d  = px_q;
            ry_d  = py_q;
            inf_d = 1'b0;
          end
          bit_done = 1'b1;
        end else if (ry_q == '0) begin
          inf_d   = 1'b1;
          state_d = StAdd;
        end else begin
          ec_valid_d = 1'b1;
          ec_px_d    = rx_q;
          ec_py_d    = ry_q;
          ec_qx_d    = rx_q;
          ec_qy_d    = ry_q;
          state_d    = StDblWait;
        end
      end

      StDblWait: begin
        if (bus.ec_out_valid) begin
          rx_d    = bus.ec_Rx;
          ry_d    = bus.ec_Ry;
          state_d = StAdd;
        end
      end

      StAdd: begin
        if (!k_q[idx_q]) begin
          bit_done = 1'b1;
        end else if (inf_q) begin
          rx_d     = px_q;
          ry_d     = py_q;
          inf_d    = 1'b0;
          bit_done = 1'b1;
        end else if (rx_q == px_q && ry_q != py_q) begin
          // R == -P, so R + P is O and must not reach the datapath.
          inf_d    = 1'b1;
          bit_done = 1'b1;
        end else begin
          ec_valid_d = 1'b1;
          ec_px_d    = px_q;
          ec_py_d    = py_q;
          ec_qx_d    = rx_q;
          ec_qy_d    = ry_q;
          state_d    = StAddWait;
        end
      end

      StAddWait: begin
        if (bus.ec_out_valid) begin
          rx_d     = bus.ec_Rx;
          ry_d     = bus.ec_Ry;
          bit_done = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (bit_done) begin
      if (idx_q == '0) begin
        state_d = StDone;
      end else begin
        idx_d   = idx_q - IdxW'(1);
        state_d = StScan;
      end
    end

    if (wd_abort) begin
      state_d = StDone;
    end

    if (state_d == StDone) begin
      out_valid_d = 1'b1;
      if (wd_abort) begin
        out_err_d = 1'b1;
      end else if (inf_d) begin
        out_inf_d = 1'b1;
      end else begin
        out_rx_d = rx_d;
        out_ry_d = ry_d;
      end
    end

    busy_d = !(state_d == StIdle || state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      px_q        <= '0;
      py_q        <= '0;
      p_q         <= '0;
      a_q         <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      inf_q       <= 1'b1;
      idx_q       <= '0;
      ec_valid_q  <= 1'b0;
      ec_px_q     <= '0;
      ec_py_q     <= '0;
      ec_qx_q     <= '0;
      ec_qy_q     <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_rx_q    <= '0;
      out_ry_q    <= '0;
      out_inf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      px_q        <= px_d;
      py_q        <= py_d;
      p_q         <= p_d;
      a_q         <= a_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      inf_q       <= inf_d;
      idx_q       <= idx_d;
      ec_valid_q  <= ec_valid_d;
      ec_px_q     <= ec_px_d;
      ec_py_q     <= ec_py_d;
      ec_qx_q     <= ec_qx_d;
      ec_qy_q     <= ec_qy_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_rx_q    <= out_rx_d;
      out_ry_q    <= out_ry_d;
      out_inf_q   <= out_inf_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_Rx      = out_rx_q;
  assign bus.out_Ry      = out_ry_q;
  assign bus.out_inf     = out_inf_q;
  assign bus.out_err     = out_err_q;
  assign bus.ec_in_valid = ec_valid_q;
  assign bus.ec_Px       = ec_px_q;
  assign bus.ec_Py       = ec_py_q;
  assign bus.ec_Qx       = ec_qx_q;
  assign bus.ec_Qy       = ec_qy_q;
  // Modulus and coefficient only change on accept, so they are stable across every op.
  assign bus.ec_prime    = p_q;
  assign bus.ec_a        = a_q;

endmodule

// File: tb/tb_ec_scalar_mul_ctrl.sv
// Randomised bench for ec_scalar_mul_ctrl: a behavioural point-op datapath stub plus a
// group-law reference (k-fold repeated addition) checked against every result pulse.
module tb_ec_scalar_mul_ctrl;
  localparam int unsigned W  = 6;
  localparam int unsigned KW = 6;
  localparam int unsigned WD = 31;

  typedef struct {
    int x;
    int y;
    bit inf;
    bit err;
  } pt_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ec_scalar_mul_ctrl_if #(.WIDTH(W), .K_WIDTH(KW)) bus ();

  ec_scalar_mul_ctrl #(.WIDTH(W), .K_WIDTH(KW), .WD_LIMIT(WD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  pt_t exp_q[$];
  int  iss_px[$], iss_py[$], iss_qx[$], iss_qy[$], iss_cyc[$];
  int  out_cyc;

  bit  st_pend = 1'b0, st_dirty = 1'b0, st_mute = 1'b0, spur_req = 1'b0;
  int  st_cnt = 0, st_lat = -1;
  logic [6*W-1:0] st_ops;
  pt_t st_res;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int md(int v, int p);
    int r;
    r = v % p;
    if (r < 0) r += p;
    return r;
  endfunction

  function automatic int inv(int v, int p);
    for (int c = 1; c < p; c++) if (md(v * c, p) == 1) return c;
    return 0;
  endfunction

  // Full affine group law, including the point at infinity.
  function automatic pt_t pt_add(pt_t a, pt_t b, int p, int ca);
    pt_t r;
    int  lam;
    r.x = 0; r.y = 0; r.inf = 1'b1; r.err = 1'b0;
    if (a.inf) return b;
    if (b.inf) return a;
    if (a.x == b.x && md(a.y + b.y, p) == 0) return r;
    if (a.x == b.x) lam = md((3 * a.x * a.x + ca) * inv(md(2 * a.y, p), p), p);
    else            lam = md((b.y - a.y) * inv(md(b.x - a.x, p), p), p);
    r.inf = 1'b0;
    r.x   = md(lam * lam - a.x - b.x, p);
    r.y   = md(lam * (a.x - r.x) - a.y, p);
    return r;
  endfunction

  function automatic pt_t ref_mul(int k, pt_t pp, int p, int ca);
    pt_t r;
    r.x = 0; r.y = 0; r.inf = 1'b1; r.err = 1'b0;
    for (int n = 0; n < k; n++) r = pt_add(r, pp, p, ca);
    return r;
  endfunction

  // Datapath stub: random latency, one result per issue, never sees a degenerate case.
  initial begin
    pt_t a, b;
    bus.ec_out_valid = 1'b0;
    bus.ec_Rx = '0;
    bus.ec_Ry = '0;
    forever begin
      @(negedge clk);
      bus.ec_out_valid = 1'b0;
      if (!rst_n) st_dirty = 1'b1;
      if (st_pend) begin
        if (st_cnt == 0) begin
          if (!st_dirty)
            chk("ec_operands_stable", {bus.ec_Px, bus.ec_Py, bus.ec_Qx, bus.ec_Qy,
                                       bus.ec_prime, bus.ec_a}, st_ops);
          bus.ec_out_valid = 1'b1;
          bus.ec_Rx = W'(st_res.x);
          bus.ec_Ry = W'(st_res.y);
          st_pend = 1'b0;
        end else begin
          st_cnt--;
        end
      end else if (spur_req) begin
        bus.ec_out_valid = 1'b1;
        bus.ec_Rx = W'($urandom_range(0, 63));
        bus.ec_Ry = W'($urandom_range(0, 63));
        spur_req = 1'b0;
      end
      if (bus.ec_in_valid === 1'b1) begin
        chk("single_outstanding", st_pend || bus.ec_out_valid, 0);
        a.x = int'(bus.ec_Px); a.y = int'(bus.ec_Py); a.inf = 1'b0; a.err = 1'b0;
        b.x = int'(bus.ec_Qx); b.y = int'(bus.ec_Qy); b.inf = 1'b0; b.err = 1'b0;
        chk("ec_no_zero_denominator",
            (a.x == b.x) && ((a.y != b.y) || (a.y == 0)), 0);
        st_res = pt_add(a, b, int'(bus.ec_prime), int'(bus.ec_a));
        st_ops = {bus.ec_Px, bus.ec_Py, bus.ec_Qx, bus.ec_Qy, bus.ec_prime, bus.ec_a};
        iss_px.push_back(a.x); iss_py.push_back(a.y);
        iss_qx.push_back(b.x); iss_qy.push_back(b.y);
        iss_cyc.push_back(cyc);
        if (!st_mute) begin
          st_pend  = 1'b1;
          st_dirty = 1'b0;
          st_cnt   = (st_lat >= 0) ? st_lat : int'($urandom_range(0, 3));
        end
      end
    end
  end

  // Result checker: every out_valid pulse against the model, zeros otherwise.
  initial begin
    pt_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_Rx", bus.out_Rx, e.x);
          chk("out_Ry", bus.out_Ry, e.y);
          chk("out_inf", bus.out_inf, e.inf);
          chk("out_err", bus.out_err, e.err);
          chk("busy_at_done", bus.busy, 0);
        end
      end else begin
        chk("outputs_zero_when_idle", {bus.out_Rx, bus.out_Ry, bus.out_inf, bus.out_err}, 0);
      end
    end
  end

  task automatic run_job(input int k, input int px, input int py, input int p, input int ca,
                         input bit again, input bit expect_err, output int lat);
    pt_t e, pp;
    int  n;
    pp.x = px; pp.y = py; pp.inf = 1'b0; pp.err = 1'b0;
    if (expect_err) begin
      e.x = 0; e.y = 0; e.inf = 1'b0; e.err = 1'b1;
    end else begin
      e = ref_mul(k, pp, p, ca);
      e.err = 1'b0;
      if (e.inf) begin e.x = 0; e.y = 0; end
    end
    iss_px.delete(); iss_py.delete(); iss_qx.delete(); iss_qy.delete(); iss_cyc.delete();
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_k     = KW'(k);
    bus.in_Px    = W'(px);
    bus.in_Py    = W'(py);
    bus.in_prime = W'(p);
    bus.in_a     = W'(ca);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    if (again) begin
      bus.in_valid = 1'b1;
      bus.in_k     = KW'(k ^ 5);
    end
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      n++;
    end
    lat     = n + 1;
    out_cyc = cyc;
    if (bus.out_valid !== 1'b1) begin
      chk("out_valid_timeout", 0, 1);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got %0d checks expected completion", checks);
    $fatal(1);
  end

  initial begin
    pt_t r, g;
    int  lat, n, p, ca, x, y, b, disc, k;
    int  primes[16] = '{5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61};

    bus.in_valid = 1'b0;
    bus.in_k     = '0;
    bus.in_Px    = '0;
    bus.in_Py    = '0;
    bus.in_prime = '0;
    bus.in_a     = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", {bus.busy, bus.out_valid, bus.out_Rx, bus.out_Ry, bus.out_inf,
                               bus.out_err, bus.ec_in_valid, bus.ec_Px, bus.ec_Py, bus.ec_Qx,
                               bus.ec_Qy, bus.ec_prime, bus.ec_a}, 0);
    rst_n = 1'b1;

    // Pin the reference model on y^2 = x^3 + x + 6 over GF(11), generator (2,7), order 13.
    g.x = 2; g.y = 7; g.inf = 1'b0; g.err = 1'b0;
    r = ref_mul(2, g, 11, 1);
    chk("model_2P", {r.x[7:0], r.y[7:0]}, {8'd5, 8'd2});
    r = ref_mul(3, g, 11, 1);
    chk("model_3P", {r.x[7:0], r.y[7:0]}, {8'd8, 8'd3});
    r = ref_mul(12, g, 11, 1);
    chk("model_12P", {r.x[7:0], r.y[7:0]}, {8'd2, 8'd4});
    r = ref_mul(13, g, 11, 1);
    chk("model_13P_inf", r.inf, 1);

    run_job(1, 2, 7, 11, 1, 0, 0, lat);
    chk("k1_issue_count", iss_px.size(), 0);

    run_job(2, 2, 7, 11, 1, 0, 0, lat);
    chk("k2_issue_count", iss_px.size(), 1);
    if (iss_px.size() == 1)
      chk("k2_double_operands", {iss_px[0][7:0], iss_py[0][7:0], iss_qx[0][7:0], iss_qy[0][7:0]},
          {8'd2, 8'd7, 8'd2, 8'd7});

    run_job(3, 2, 7, 11, 1, 0, 0, lat);
    chk("k3_issue_count", iss_px.size(), 2);
    if (iss_px.size() == 2)
      chk("k3_add_operands", {iss_px[1][7:0], iss_py[1][7:0], iss_qx[1][7:0], iss_qy[1][7:0]},
          {8'd2, 8'd7, 8'd5, 8'd2});

    // 13P: three doublings plus one add; the closing (2,4)+(2,7) is resolved locally.
    run_job(13, 2, 7, 11, 1, 0, 0, lat);
    chk("k13_issue_count", iss_px.size(), 4);

    spur_req = 1'b1;
    repeat (4) @(negedge clk);

    run_job(0, 2, 7, 11, 1, 1, 0, lat);
    chk("k0_issue_count", iss_px.size(), 0);
    chk("k0_latency_bound", lat <= int'(2 + KW), 1);

    // Reset while the first doubling of k=3 is outstanding.
    st_lat = 6;
    iss_px.delete(); iss_py.delete(); iss_qx.delete(); iss_qy.delete(); iss_cyc.delete();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_k     = KW'(3);
    bus.in_Px    = W'(2);
    bus.in_Py    = W'(7);
    bus.in_prime = W'(11);
    bus.in_a     = W'(1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (iss_px.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_issue_seen", iss_px.size(), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_zero", {bus.busy, bus.out_valid, bus.out_Rx, bus.out_Ry, bus.out_inf,
                           bus.out_err, bus.ec_in_valid, bus.ec_Px, bus.ec_Py, bus.ec_Qx,
                           bus.ec_Qy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    st_lat = -1;
    run_job(2, 2, 7, 11, 1, 0, 0, lat);
    chk("post_reset_issue_count", iss_px.size(), 1);

    // Random curves (non-singular), points and scalars.
    for (int t = 0; t < 40; t++) begin
      p = primes[$urandom_range(0, 15)];
      do begin
        ca   = int'($urandom_range(0, p - 1));
        x    = int'($urandom_range(0, p - 1));
        y    = int'($urandom_range(0, p - 1));
        b    = md(y * y - x * x * x - ca * x, p);
        disc = md(4 * ca * ca * ca + 27 * b * b, p);
      end while (disc == 0);
      k = int'($urandom_range(0, (1 << KW) - 1));
      run_job(k, x, y, p, ca, 0, 0, lat);
    end

`ifdef ECSM_WATCHDOG_EN
    st_mute = 1'b1;
    run_job(2, 2, 7, 11, 1, 0, 1, lat);
    chk("wd_issue_count", iss_px.size(), 1);
    if (iss_cyc.size() > 0) chk("wd_latency", out_cyc - iss_cyc[0], WD);
    st_mute = 1'b0;
    run_job(3, 2, 7, 11, 1, 0, 0, lat);
    chk("wd_recover_issue_count", iss_px.size(), 2);
`endif

    repeat (5) @(negedge clk);
    chk("no_leftover_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ec_scalar_mul_ctrl.md
Name: ec_scalar_mul_ctrl

Overview:
- Sequences the existing single-cycle-issue EC point add/double datapath to compute the scalar multiple R = k·P over GF(p).
- Uses left-to-right double-and-add. Issues one datapath operation at a time and waits for its result.
- Handles the point at infinity (O) itself, because the datapath cannot represent O and must never see a zero-denominator case.
- Sits between the testbench/host interface and the point-operation unit.

Parameters:
- WIDTH, 6, bit width of coordinates, prime and curve coefficient a
- K_WIDTH, 6, bit width of scalar k
- WD_LIMIT, 31, watchdog cycle limit (used only with ECSM_WATCHDOG_EN)

Ports:
- clk  input  1  clock
- rst_n  input  1  async active-low reset
- in_valid  input  1  one-cycle start pulse; operands valid this cycle
- in_k  input  K_WIDTH  scalar
- in_Px, in_Py  input  WIDTH  base point P (on the curve)
- in_prime  input  WIDTH  modulus p
- in_a  input  WIDTH  curve coefficient a
- busy  output  1  high from the cycle after accept until out_valid
- out_valid  output  1  one-cycle result pulse
- out_Rx, out_Ry  output  WIDTH  result (0,0 when out_inf=1); 0 when out_valid=0
- out_inf  output  1  result is O; 0 when out_valid=0
- out_err  output  1  watchdog abort (tied 0 without macro)
- ec_in_valid  output  1  one-cycle issue pulse to the datapath
- ec_Px, ec_Py, ec_Qx, ec_Qy, ec_prime, ec_a  output  WIDTH  datapath operands, held stable from issue until result
- ec_out_valid  input  1  datapath result pulse
- ec_Rx, ec_Ry  input  WIDTH  datapath result

Behaviour:
- Clocking/reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: all outputs 0, state IDLE, accumulator flag inf=1.
- IDLE: on in_valid, latch k, P, p and a. Set R=O, bit index i=K_WIDTH-1, then go to SCAN. in_valid outside IDLE is ignored.
- SCAN, per bit i:
  - If inf=0: go to DBL_ISSUE.
  - If inf=1: go directly to the add step.
- DBL_ISSUE:
  - If Ry==0: set inf=1 and skip the issue.
  - Otherwise drive P=Q=R, pulse ec_in_valid for one cycle, then go to DBL_WAIT.
- DBL_WAIT: on ec_out_valid, load R from ec_Rx/ec_Ry, then go to the add step.
- Add step, if k[i]=1:
  - If inf=1: R=P, inf=0, no issue.
  - Else if Rx==Px and Ry!=Py: inf=1, no issue (R = -P).
  - Else drive P=P, Q=R, pulse ec_in_valid, wait in ADD_WAIT, then load R. The datapath self-selects doubling when R==P.
- Add step, if k[i]=0: no action.
- NEXT: if i==0 go to DONE, else decrement i and go to SCAN.
- DONE: pulse out_valid one cycle with R/out_inf, then go to IDLE. busy drops in the same cycle.
- Datapath latency is unknown to the controller. It waits on ec_out_valid only.
- Spurious ec_out_valid outside the WAIT states is ignored.
- At most one operation is outstanding. ec_in_valid is never asserted in a WAIT state.
- k=0: no operations issued; result is O, out_valid 2+K_WIDTH cycles after accept at most.
- Operand comparisons are on the latched registers. All arithmetic is delegated to the datapath; the controller does no mod-p math.
- Reset mid-operation: abort immediately to IDLE with no out_valid. Any datapath result arriving after reset is ignored.

Optional Feature:
- ECSM_WATCHDOG_EN defined: a counter runs in each WAIT state.
  - If WD_LIMIT cycles pass without ec_out_valid: pulse out_valid with out_err=1, Rx=Ry=0, out_inf=0, and go to IDLE.
  - The counter resets on every issue.
- Undefined: no counter; out_err tied 0; the controller waits indefinitely.

Test Plan:
- Curve p=11, a=1, P=(2,7):
  - k=1 → (2,7), inf=0, zero ec_in_valid pulses.
  - k=2 → (5,2), exactly one issue with P=Q=(2,7).
- Same curve, k=3 → (8,3), two issues: one double, then one add with Q=(5,2).
- Same curve, k=13 → out_inf=1, Rx=Ry=0. The final add (2,4)+(2,7) is not issued.
- k=0 → out_inf=1, zero issues. in_valid pulsed again while busy → ignored, single out_valid.
- Reset asserted in DBL_WAIT during k=3 → all outputs 0 asynchronously, no out_valid. A late ec_out_valid is ignored. A new k=2 run → (5,2).
- With ECSM_WATCHDOG_EN, datapath stub never responds → out_valid with out_err=1 WD_LIMIT cycles after the first issue; then IDLE accepts a new job.
